// File: rtl/core_pkg.sv
// core_pkg: shared width constants and arbiter owner encoding
package core_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int DATA_MEM_ADDR_WIDTH = 10;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} arb_owner_e;
endpackage

// File: rtl/starve_counter.sv
// starve_counter: saturating count of data grants taken while a fetch waits
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = LIMIT > 0 ? $clog2(LIMIT + 1) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign sat = cnt_q == W'(LIMIT);
  always_comb cnt_d = clr ? '0 : (inc && !sat) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between fetch and data requesters
module mem_arbiter
  import core_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_WIDTH = DATA_MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [3:0]            d_be_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_if_o
);
  arb_owner_e owner_q, owner_d;
  logic sat, if_gnt, d_gnt;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[DATA_WIDTH-1:ADDR_WIDTH+2], if_addr_i[1:0],
                              d_addr_i[DATA_WIDTH-1:ADDR_WIDTH+2], d_addr_i[1:0]};
  // data wins unless the waiting fetch has been passed over STARVE_LIMIT times
  always_comb begin
    d_gnt = !rst && d_req_i && !(if_req_i && sat);
    if_gnt = !rst && if_req_i && !d_gnt;
    owner_d = rst ? OWN_NONE : if_gnt ? OWN_FETCH : (d_gnt && !d_we_i) ? OWN_DATA : OWN_NONE;
  end
  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk),
    .rst(rst),
    .inc(d_gnt && if_req_i),
    .clr(rst || !if_req_i || if_gnt),
    .sat(sat)
  );
  always_ff @(posedge clk) begin
    if (rst) owner_q <= OWN_NONE;
    else owner_q <= owner_d;
  end
  assign if_gnt_o = if_gnt;
  assign d_gnt_o = d_gnt;
  assign stall_if_o = if_req_i && !if_gnt;
  assign mem_en_o = if_gnt || d_gnt;
  assign mem_we_o = (d_gnt && d_we_i) ? d_be_i : 4'h0;
  assign mem_addr_o = if_gnt ? if_addr_i[ADDR_WIDTH+1:2] : d_addr_i[ADDR_WIDTH+1:2];
  assign mem_wdata_o = d_wdata_i;
  // a read in flight when reset hits is dropped rather than reported
  assign if_rvalid_o = !rst && owner_q == OWN_FETCH;
  assign d_rvalid_o = !rst && owner_q == OWN_DATA;
  assign if_rdata_o = mem_rdata_i;
  assign d_rdata_o = mem_rdata_i;
endmodule
